pc_sequencer: RTL and testbench

Owns and sequences the program counter of the single-cycle core: boot from reset vector, sequential +4 advance, branch/jump redirect, stall freeze, ebreak halt/resume, and misaligned-target trap.
Replaces free-running PC update logic. Feeds instruction-memory address and pc_plus4 to writeback (jal/jalr link).

---
 rtl/pc_seq_pkg.sv | 27 ++
 rtl/pc_target_sel.sv | 43 ++++
 rtl/pc_sequencer.sv | 102 ++++++++++
 tb/tb_pc_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
//   state_t      : sequencer FSM states
//   trap_cause_t : encoding reported on trap_cause
//   INSTR_BYTES  : sequential fetch stride
package pc_seq_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        TRAP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE         = 2'd0,
        CAUSE_BR_MISALIGN  = 2'd1,
        CAUSE_JMP_MISALIGN = 2'd2
    } trap_cause_t;

    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Instruction targets must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Next-PC target selection for the RUN state (purely combinational).
// Ports:
//   pc_plus4       in  32  sequential successor of the current pc
//   branch_taken   in   1  conditional branch resolved taken
//   branch_target  in  32  branch destination
//   jump           in   1  jal/jalr redirect (wins over branch)
//   jump_target    in  32  jump destination
//   next_target    out 32  selected next pc
//   misaligned     out  1  selected redirect target is not word aligned
//   cause          out  2  trap cause if misaligned, else CAUSE_NONE
module pc_target_sel
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] next_target,
    output logic        misaligned,
    output trap_cause_t cause
);

    always_comb begin
        next_target = pc_plus4;
        misaligned  = 1'b0;
        cause       = CAUSE_NONE;
        if (jump) begin
            next_target = jump_target;
            if (is_misaligned(jump_target)) begin
                misaligned = 1'b1;
                cause      = CAUSE_JMP_MISALIGN;
            end
        end else if (branch_taken) begin
            next_target = branch_target;
            if (is_misaligned(branch_target)) begin
                misaligned = 1'b1;
                cause      = CAUSE_BR_MISALIGN;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner for the single-cycle core: boot, +4 advance,
// branch/jump redirect, stall freeze, ebreak halt/resume, misaligned trap.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   stall                 freeze pc and state this cycle
//   branch_taken/_target  conditional branch redirect
//   jump/jump_target      jal/jalr redirect
//   halt_req, resume      enter / leave HALT
//   pc, pc_plus4          fetch address and its +4 successor
//   fetch_valid, halted, trap   Moore decodes of the state
//   trap_cause, trap_epc  last trap record, held until next trap or reset
//
// state | meaning
// BOOT  | one idle cycle after reset, pc = RESET_VECTOR, no fetch
// RUN   | fetching at pc, advancing or redirecting every unstalled edge
// HALT  | ebreak reached, pc frozen on it until resume
// TRAP  | single cycle after a misaligned redirect, pc = TRAP_VECTOR
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic        trap,
    output logic [1:0]  trap_cause,
    output logic [31:0] trap_epc
);

    state_t      state;
    logic [31:0] next_target;
    logic        misaligned;
    trap_cause_t sel_cause;

    assign pc_plus4 = pc + INSTR_BYTES;

    pc_target_sel u_target_sel (
        .pc_plus4      (pc_plus4),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .next_target   (next_target),
        .misaligned    (misaligned),
        .cause         (sel_cause)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            trap_cause <= CAUSE_NONE;
            trap_epc   <= 32'h0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    // Stall dominates everything: the source holds its
                    // request until the freeze is released.
                    if (!stall) begin
                        if (halt_req) begin
                            state <= HALT;
                        end else if (misaligned) begin
                            pc         <= TRAP_VECTOR;
                            trap_epc   <= pc;
                            trap_cause <= sel_cause;
                            state      <= TRAP;
                        end else begin
                            pc <= next_target;
                        end
                    end
                end
                HALT: begin
                    // Resume skips over the ebreak the pc is parked on.
                    if (resume) begin
                        pc    <= pc_plus4;
                        state <= RUN;
                    end
                end
                TRAP: state <= RUN;
                default: state <= BOOT;
            endcase
        end
    end

    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);
    assign trap        = (state == TRAP);

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt_req;
    logic        resume;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        halted;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] trap_epc;

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .halted        (halted),
        .trap          (trap),
        .trap_cause    (trap_cause),
        .trap_epc      (trap_epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        halt_req;
        logic        resume;
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic [31:0] e_pc;
        logic        e_fv;
        logic        e_halted;
        logic        e_trap;
        logic [1:0]  e_cause;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step=%0d got=0x%08h want=0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [31:0] e_pc, input logic e_fv, input logic e_h,
                           input logic e_t, input logic [1:0] e_c, input logic [31:0] e_e);
        chk("pc", idx, pc, e_pc);
        chk("pc_plus4", idx, pc_plus4, e_pc + 32'd4);
        chk("fetch_valid", idx, {31'd0, fetch_valid}, {31'd0, e_fv});
        chk("halted", idx, {31'd0, halted}, {31'd0, e_h});
        chk("trap", idx, {31'd0, trap}, {31'd0, e_t});
        chk("trap_cause", idx, {30'd0, trap_cause}, {30'd0, e_c});
        chk("trap_epc", idx, trap_epc, e_e);
    endtask

    task automatic idle_inputs();
        stall = 0; halt_req = 0; resume = 0;
        jump = 0; jump_target = 0; branch_taken = 0; branch_target = 0;
    endtask

    function automatic vec_t mk(input logic s, input logic h, input logic r, input logic j,
                                input logic [31:0] jt, input logic b, input logic [31:0] bt,
                                input logic [31:0] pcx, input logic fv, input logic hl,
                                input logic tr, input logic [1:0] c, input logic [31:0] e);
        vec_t v;
        v.stall = s; v.halt_req = h; v.resume = r; v.jump = j; v.jt = jt;
        v.br = b; v.bt = bt; v.e_pc = pcx; v.e_fv = fv; v.e_halted = hl;
        v.e_trap = tr; v.e_cause = c; v.e_epc = e;
        return v;
    endfunction

    initial begin
        //           st h  r  j  jt            b  bt          pc            fv hl tr c  epc
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,        1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h4,        1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h8,        1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h8,        1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,  32'h8,        1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h40, 32'h8,        1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'hC,        1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h200,      1, 32'h80, 32'h200,      1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h80, 32'h80,       1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 32'h10,       0, 32'h0,  32'h10,       1, 0, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h22, 32'h100,      0, 0, 1, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h300,      0, 32'h0,  32'h100,      1, 0, 0, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h104,      1, 0, 0, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h30,       0, 32'h0,  32'h30,       1, 0, 0, 1, 32'h10));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,  32'h30,       0, 1, 0, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h80,       0, 32'h0,  32'h30,       0, 1, 0, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h80,       0, 32'h0,  32'h30,       0, 1, 0, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h81,       0, 32'h0,  32'h30,       0, 1, 0, 1, 32'h10));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h80, 32'h30,       0, 1, 0, 1, 32'h10));
        vecs.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h0,  32'h34,       1, 0, 0, 1, 32'h10));
        vecs.push_back(mk(0, 0, 0, 1, 32'h3,        1, 32'h2,  32'h100,      0, 0, 1, 2, 32'h34));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h100,      1, 0, 0, 2, 32'h34));
        vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'hFFFF_FFFC, 1, 0, 0, 2, 32'h34));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h0,        1, 0, 0, 2, 32'h34));
        vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,  32'h0,        1, 0, 0, 2, 32'h34));
        vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,  32'h4,        1, 0, 0, 2, 32'h34));
        vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,  32'h4,        0, 1, 0, 2, 32'h34));

        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all(-1, 32'h0, 0, 0, 0, 0, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all(-2, 32'h0, 0, 0, 0, 0, 32'h0);

        foreach (vecs[i]) begin
            stall         = vecs[i].stall;
            halt_req      = vecs[i].halt_req;
            resume        = vecs[i].resume;
            jump          = vecs[i].jump;
            jump_target   = vecs[i].jt;
            branch_taken  = vecs[i].br;
            branch_target = vecs[i].bt;
            @(posedge clk); #1;
            chk_all(i, vecs[i].e_pc, vecs[i].e_fv, vecs[i].e_halted,
                    vecs[i].e_trap, vecs[i].e_cause, vecs[i].e_epc);
        end

        // Async reset asserted mid-cycle while halted at pc=0x4.
        idle_inputs();
        #2;
        rst = 1'b1;
        #1;
        chk_all(100, 32'h0, 0, 0, 0, 0, 32'h0);

        // Release and confirm a clean BOOT -> RUN restart.
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_all(101, 32'h0, 1, 0, 0, 0, 32'h0);
        @(posedge clk); #1;
        chk_all(102, 32'h4, 1, 0, 0, 0, 32'h0);

        // Reset during RUN, released, BOOT cycle holds pc with no fetch.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_all(103, 32'h0, 0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk_all(104, 32'h0, 1, 0, 0, 0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
